// File: rtl/rom_read_frontend_pkg.sv
// Shared constants and the response-entry layout for the boot ROM read front end.
package rom_read_frontend_pkg;

  localparam int unsigned ROM_ADDR_W   = 10;
  localparam int unsigned ROM_SIZE     = 1024;
  localparam logic [31:0] BOOTROM_BASE = 32'h0000_0000;
  localparam int unsigned RESP_ENTRY_W = 65;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
    logic        err;
  } resp_entry_t;

endpackage

// File: rtl/rom_read_frontend_if.sv
// Request/response handshake bundle between the fetch/load path and the ROM front end.
interface rom_read_frontend_if;

  logic        REQ_VALID;
  logic        REQ_READY;
  logic [31:0] REQ_ADDR;
  logic        RESP_VALID;
  logic        RESP_READY;
  logic [31:0] RESP_DATA;
  logic [31:0] RESP_ADDR;
  logic        RESP_ERR;

  modport master (
    output REQ_VALID, REQ_ADDR, RESP_READY,
    input  REQ_READY, RESP_VALID, RESP_DATA, RESP_ADDR, RESP_ERR
  );

  modport slave (
    input  REQ_VALID, REQ_ADDR, RESP_READY,
    output REQ_READY, RESP_VALID, RESP_DATA, RESP_ADDR, RESP_ERR
  );

endinterface

// File: rtl/rom_read_frontend_fifo.sv
// First-word fall-through synchronous FIFO; head data is read combinationally at the read pointer.
module sync_fifo_fwft #(
  parameter int unsigned DATA_W = 65,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     PUSH,
  input  logic [DATA_W-1:0]        PDATA,
  input  logic                     POP,
  output logic [DATA_W-1:0]        HDATA,
  output logic                     EMPTY,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [PtrW:0]     count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (PUSH) wptr_d = wptr_q + 1'b1;
    if (POP)  rptr_d = rptr_q + 1'b1;
    unique case ({PUSH, POP})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is reset so the head outputs read as zero while empty after reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (PUSH) mem_q[wptr_q] <= PDATA;
    end
  end

  assign HDATA = mem_q[rptr_q];
  assign EMPTY = (count_q == '0);
  assign COUNT = count_q;

endmodule

// File: rtl/rom_read_frontend.sv
// Boot ROM read-port front end: range/alignment check, one-cycle pending stage, credit-based
// issue into a response FIFO so consumer backpressure never drops returned data.
module rom_read_frontend
  import rom_read_frontend_pkg::*;
#(
  parameter int unsigned WIDTH      = ROM_ADDR_W,
  parameter int unsigned SIZE       = ROM_SIZE,
  parameter logic [31:0] BASE_ADDR  = BOOTROM_BASE,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  rom_read_frontend_if.slave   bus,
  output logic                 ROM_RDEN,
  output logic [WIDTH-1:0]     ROM_RIADDR,
  input  logic                 ROM_RVALID,
  input  logic [31:0]          ROM_RDATA,
  input  logic [WIDTH-1:0]     ROM_ROADDR
);

  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned UsedW = CntW + 1;
  localparam logic [32:0] RangeBytes = 33'(SIZE) * 33'd4;

  logic              req_ready;
  logic              accept;
  logic              req_err;
  logic [32:0]       offset;
  logic [UsedW-1:0]  used;
  logic              p_valid_q, p_valid_d;
  logic              p_err_q, p_err_d;
  logic [31:0]       p_addr_q, p_addr_d;
  logic [CntW-1:0]   fifo_count;
  logic              fifo_empty;
  logic              pop;
  resp_entry_t       push_entry;
  resp_entry_t       head_entry;

  // Credit: a slot is reserved for every read still in the pending stage.
  always_comb begin
    used      = UsedW'(fifo_count) + UsedW'(p_valid_q);
    req_ready = RST && (used < UsedW'(FIFO_DEPTH));
  end

  always_comb begin
    // 33-bit subtraction so an address below the base cannot wrap into range.
    offset     = {1'b0, bus.REQ_ADDR} - {1'b0, BASE_ADDR};
    req_err    = (bus.REQ_ADDR[1:0] != 2'b00) || offset[32] || (offset >= RangeBytes);
    accept     = bus.REQ_VALID && req_ready;
    ROM_RDEN   = accept && !req_err;
    ROM_RIADDR = accept ? offset[WIDTH+1:2] : '0;
    p_valid_d  = accept;
    p_err_d    = p_err_q;
    p_addr_d   = p_addr_q;
    if (accept) begin
      p_err_d  = req_err;
      p_addr_d = bus.REQ_ADDR;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p_valid_q <= 1'b0;
      p_err_q   <= 1'b0;
      p_addr_q  <= '0;
    end else begin
      p_valid_q <= p_valid_d;
      p_err_q   <= p_err_d;
      p_addr_q  <= p_addr_d;
    end
  end

  always_comb begin
    push_entry.data = p_err_q ? 32'h0 : ROM_RDATA;
    push_entry.addr = p_addr_q;
    push_entry.err  = p_err_q;
    pop             = !fifo_empty && bus.RESP_READY;
  end

  sync_fifo_fwft #(
    .DATA_W (RESP_ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_resp_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .PUSH  (p_valid_q),
    .PDATA (push_entry),
    .POP   (pop),
    .HDATA (head_entry),
    .EMPTY (fifo_empty),
    .COUNT (fifo_count)
  );

  assign bus.REQ_READY  = req_ready;
  assign bus.RESP_VALID = !fifo_empty;
  assign bus.RESP_DATA  = head_entry.data;
  assign bus.RESP_ADDR  = head_entry.addr;
  assign bus.RESP_ERR   = head_entry.err;

`ifndef SYNTHESIS
  // Skips the first edge after reset release so a stale ROM return is not flagged.
  logic chk_en_q;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) chk_en_q <= 1'b0;
    else      chk_en_q <= 1'b1;
  end

  rvalid_consistent: assert property (@(posedge CLK) disable iff (!RST || !chk_en_q)
    ROM_RVALID == (p_valid_q && !p_err_q));

  roaddr_consistent: assert property (@(posedge CLK) disable iff (!RST || !chk_en_q)
    ROM_RVALID |-> (ROM_ROADDR == WIDTH'((p_addr_q - BASE_ADDR) >> 2)));
`endif

endmodule

// File: tb/tb_rom_read_frontend.sv
// Directed bench for rom_read_frontend with a one-cycle-latency ROM model.
module tb_rom_read_frontend;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_rden;
  logic [9:0]  rom_riaddr;
  logic        rom_rvalid = 1'b0;
  logic [31:0] rom_rdata  = '0;
  logic [9:0]  rom_roaddr = '0;
  logic [31:0] rom_mem [1024];

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] mx_addr [3] = '{32'h8, 32'h9, 32'hC};
  logic [31:0] mx_data [3] = '{32'hA500_0002, 32'h0, 32'hA500_0003};
  logic        mx_err  [3] = '{1'b0, 1'b1, 1'b0};
  logic        mx_rden [3] = '{1'b1, 1'b0, 1'b1};

  rom_read_frontend_if bus ();

  rom_read_frontend u_dut (
    .CLK        (clk),
    .RST        (rst),
    .bus        (bus),
    .ROM_RDEN   (rom_rden),
    .ROM_RIADDR (rom_riaddr),
    .ROM_RVALID (rom_rvalid),
    .ROM_RDATA  (rom_rdata),
    .ROM_ROADDR (rom_roaddr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_rvalid <= rom_rden;
    if (rom_rden) begin
      rom_rdata  <= rom_mem[rom_riaddr];
      rom_roaddr <= rom_riaddr;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated request; response is held two cycles after accept and then popped.
  task automatic single(input string tag, input logic [31:0] addr, input logic exp_rden,
                        input logic [31:0] exp_data, input logic exp_err);
    bus.REQ_VALID  = 1'b1;
    bus.REQ_ADDR   = addr;
    bus.RESP_READY = 1'b0;
    #1;
    check({tag, ".req_ready"}, 32'(bus.REQ_READY), 32'd1);
    check({tag, ".rden"}, 32'(rom_rden), 32'(exp_rden));
    if (exp_rden) check({tag, ".riaddr"}, 32'(rom_riaddr), addr >> 2);
    tick();
    bus.REQ_VALID = 1'b0;
    check({tag, ".valid_n1"}, 32'(bus.RESP_VALID), 32'd0);
    tick();
    check({tag, ".valid_n2"}, 32'(bus.RESP_VALID), 32'd1);
    check({tag, ".data"}, bus.RESP_DATA, exp_data);
    check({tag, ".addr"}, bus.RESP_ADDR, addr);
    check({tag, ".err"}, 32'(bus.RESP_ERR), 32'(exp_err));
    bus.RESP_READY = 1'b1;
    tick();
    bus.RESP_READY = 1'b0;
    check({tag, ".drained"}, 32'(bus.RESP_VALID), 32'd0);
  endtask

  initial begin
    int          acc;
    logic        took;
    logic [31:0] next_addr;

    for (int i = 0; i < 1024; i++) rom_mem[i] = 32'hA500_0000 | 32'(i);
    rst            = 1'b0;
    bus.REQ_VALID  = 1'b1;
    bus.REQ_ADDR   = 32'h10;
    bus.RESP_READY = 1'b1;
    tick();
    tick();
    check("rst.req_ready", 32'(bus.REQ_READY), 32'd0);
    check("rst.rden", 32'(rom_rden), 32'd0);
    check("rst.resp_valid", 32'(bus.RESP_VALID), 32'd0);
    check("rst.resp_data", bus.RESP_DATA, 32'd0);
    check("rst.resp_addr", bus.RESP_ADDR, 32'd0);
    check("rst.resp_err", 32'(bus.RESP_ERR), 32'd0);
    bus.REQ_VALID = 1'b0;
    rst           = 1'b1;
    #1;
    check("rst.release_ready", 32'(bus.REQ_READY), 32'd1);
    tick();

    single("rd10", 32'h0000_0010, 1'b1, 32'hA500_0004, 1'b0);
    single("mis06", 32'h0000_0006, 1'b0, 32'h0, 1'b1);
    single("oor1000", 32'h0000_1000, 1'b0, 32'h0, 1'b1);
    single("top0ffc", 32'h0000_0FFC, 1'b1, 32'hA500_03FF, 1'b0);
    single("oorfffc", 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1);

    bus.RESP_READY = 1'b1;
    for (int i = 0; i < 18; i++) begin
      bus.REQ_VALID = (i < 16);
      bus.REQ_ADDR  = 32'(i * 4);
      #1;
      if (i < 16) check("stream.req_ready", 32'(bus.REQ_READY), 32'd1);
      if (i >= 2) begin
        check("stream.valid", 32'(bus.RESP_VALID), 32'd1);
        check("stream.data", bus.RESP_DATA, 32'hA500_0000 | 32'(i - 2));
      end
      tick();
    end
    bus.REQ_VALID = 1'b0;
    #1;
    check("stream.empty", 32'(bus.RESP_VALID), 32'd0);
    tick();

    bus.RESP_READY = 1'b0;
    next_addr      = 32'h40;
    acc            = 0;
    for (int i = 0; i < 8; i++) begin
      bus.REQ_VALID = 1'b1;
      bus.REQ_ADDR  = next_addr;
      #1;
      took = bus.REQ_READY;
      if (took) acc++;
      tick();
      if (took) next_addr = next_addr + 32'd4;
    end
    bus.REQ_VALID = 1'b0;
    check("bp.accepted", 32'(acc), 32'd4);
    check("bp.ready_low", 32'(bus.REQ_READY), 32'd0);
    bus.RESP_READY = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      check("bp.valid", 32'(bus.RESP_VALID), 32'd1);
      check("bp.data", bus.RESP_DATA, 32'hA500_0010 + 32'(j));
      check("bp.addr", bus.RESP_ADDR, 32'h40 + 32'(4 * j));
      check("bp.req_ready", 32'(bus.REQ_READY), 32'(j > 0));
      tick();
    end
    #1;
    check("bp.empty", 32'(bus.RESP_VALID), 32'd0);
    tick();

    for (int i = 0; i < 5; i++) begin
      bus.REQ_VALID = (i < 3);
      if (i < 3) bus.REQ_ADDR = mx_addr[i];
      #1;
      if (i < 3) check("mix.rden", 32'(rom_rden), 32'(mx_rden[i]));
      if (i >= 2) begin
        check("mix.valid", 32'(bus.RESP_VALID), 32'd1);
        check("mix.data", bus.RESP_DATA, mx_data[i - 2]);
        check("mix.addr", bus.RESP_ADDR, mx_addr[i - 2]);
        check("mix.err", 32'(bus.RESP_ERR), 32'(mx_err[i - 2]));
      end
      tick();
    end
    bus.REQ_VALID = 1'b0;

    bus.RESP_READY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.REQ_VALID = 1'b1;
      bus.REQ_ADDR  = 32'h20 + 32'(4 * i);
      #1;
      check("mrst.fill_ready", 32'(bus.REQ_READY), 32'd1);
      tick();
    end
    bus.REQ_VALID = 1'b0;
    #1;
    check("mrst.queued", 32'(bus.RESP_VALID), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("mrst.resp_valid", 32'(bus.RESP_VALID), 32'd0);
    check("mrst.req_ready", 32'(bus.REQ_READY), 32'd0);
    check("mrst.resp_data", bus.RESP_DATA, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mrst.no_stale", 32'(bus.RESP_VALID), 32'd0);
      tick();
    end
    single("mrst.after", 32'h0000_0030, 1'b1, 32'hA500_000C, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
